// File: rtl/handshake_merge.sv
// Merges NUM_IN return-to-zero en/ack input channels into one tagged en/ack output
// through round-robin arbitration and a DEPTH-entry FIFO.
module handshake_merge #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4,
  parameter int SRC_W  = $clog2(NUM_IN),
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] channel_in_data,
  input  logic [NUM_IN-1:0]       channel_in_en,
  output logic [NUM_IN-1:0]       channel_in_ack,
  output logic [WIDTH-1:0]        channel_out_data,
  output logic [SRC_W-1:0]        channel_out_src,
  output logic                    channel_out_en,
  input  logic                    channel_out_ack,
  output logic [LVL_W-1:0]        fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_VALID, O_GAP} out_state_t;

  in_state_t             in_state      [NUM_IN];
  in_state_t             in_state_next [NUM_IN];
  out_state_t            out_state;
  out_state_t            out_state_next;

  logic [SRC_W-1:0]      rr_ptr;
  logic [NUM_IN-1:0]     grant;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [SRC_W-1:0]      sel;
  int                    ack_cnt;
  int                    idx;

  logic                  push;
  logic [WIDTH-1:0]      push_data;
  logic [SRC_W-1:0]      push_src;
  logic                  pop;

  logic [WIDTH-1:0]      mem     [DEPTH];
  logic [SRC_W-1:0]      src_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  out_en_next;
  logic [WIDTH-1:0]      out_data_next;
  logic [SRC_W-1:0]      out_src_next;

  // Grant only when the FIFO can absorb every ACK already in flight plus this one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel       = '0;
    ack_cnt   = 0;
    idx       = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_state[i] == ACK) ack_cnt = ack_cnt + 1;
    end
    if (int'(fifo_level) + ack_cnt < DEPTH) begin
      for (int off = 0; off < NUM_IN; off++) begin
        idx = int'(rr_ptr) + off;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        sel = SRC_W'(idx);
        if (!grant_any && in_state[sel] == IDLE && channel_in_en[sel]) begin
          grant_any = 1'b1;
          grant_idx = sel;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_src  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      channel_in_ack[i] = (in_state[i] == ACK);
      if (in_state[i] == ACK && channel_in_en[i]) begin
        push      = 1'b1;
        push_data = channel_in_data[i*WIDTH +: WIDTH];
        push_src  = SRC_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_state_next[i] = in_state[i];
      case (in_state[i])
        IDLE:     if (grant[i]) in_state_next[i] = ACK;
        ACK:      in_state_next[i] = channel_in_en[i] ? WAIT_LOW : IDLE;
        WAIT_LOW: if (!channel_in_en[i]) in_state_next[i] = IDLE;
        default:  in_state_next[i] = IDLE;
      endcase
    end
  end

  // O_GAP already drives en low for its cycle, so it loads the next head directly
  // to sustain one word every two cycles.
  always_comb begin
    out_state_next = out_state;
    out_en_next    = channel_out_en;
    out_data_next  = channel_out_data;
    out_src_next   = channel_out_src;
    pop            = 1'b0;
    case (out_state)
      O_IDLE, O_GAP: begin
        out_state_next = O_IDLE;
        if (fifo_level != '0) begin
          out_state_next = O_VALID;
          out_en_next    = 1'b1;
          out_data_next  = mem[rd_ptr];
          out_src_next   = src_mem[rd_ptr];
        end
      end
      O_VALID: begin
        if (channel_out_ack) begin
          pop            = 1'b1;
          out_en_next    = 1'b0;
          out_state_next = O_GAP;
        end
      end
      default: out_state_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) in_state[i] <= IDLE;
      out_state        <= O_IDLE;
      rr_ptr           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_level       <= '0;
      channel_out_en   <= 1'b0;
      channel_out_data <= '0;
      channel_out_src  <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) in_state[i] <= in_state_next[i];
      out_state        <= out_state_next;
      channel_out_en   <= out_en_next;
      channel_out_data <= out_data_next;
      channel_out_src  <= out_src_next;
      if (grant_any) begin
        rr_ptr <= (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SRC_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= push_data;
      src_mem[wr_ptr] <= push_src;
    end
  end

endmodule
